// File: rtl/sqrt_controller.sv
// sqrt_controller: sequences the FP_Datapath to compute floor(sqrt(N)) by
// subtracting successive odd numbers from N. The count of odd numbers that
// were subtracted before the remainder would go negative is the root.
//
// Handshake: the host raises start_i with operand_i valid. The request is
// taken only at a rising edge where the FSM is in IDLE, and busy_o rises in the
// next cycle. done_o pulses for exactly one cycle when the datapath data_o
// holds the result. err_o is meaningful only while done_o is high. start_i is
// ignored in every state except IDLE, and that includes DONE.
module sqrt_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic                  negative_o_i,
  output logic                  IE,
  output logic                  WE,
  output logic                  OE,
  output logic [2:0]            ADDR_WR,
  output logic [2:0]            ADDR_RDA,
  output logic [2:0]            ADDR_RDB,
  output logic [1:0]            ALU_Op,
  output logic [DATA_WIDTH-1:0] dp_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Register-file map used by the sequence
  localparam logic [2:0] R_REM  = 3'd0;
  localparam logic [2:0] R_ODD  = 3'd1;
  localparam logic [2:0] R_CNT  = 3'd2;
  localparam logic [2:0] R_ONE  = 3'd3;
  localparam logic [2:0] R_TWO  = 3'd4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LD_N    = 4'd1,
    S_LD_ODD  = 4'd2,
    S_LD_ONE  = 4'd3,
    S_LD_TWO  = 4'd4,
    S_LD_CNT  = 4'd5,
    S_SUB     = 4'd6,
    S_ADD_ODD = 4'd7,
    S_INC     = 4'd8,
    S_OUT     = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] operand_q;
  logic                  err_q;
  logic                  accept;

  assign accept = (state == S_IDLE) && start_i;

  // State register plus operand/error capture on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      operand_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        operand_q <= operand_i;
        err_q     <= operand_i[DATA_WIDTH-1];
      end
    end
  end

  // Next-state and Moore-style control decode. WE in SUB is the one exception:
  // it follows the datapath sign so a negative difference is never written back.
  always_comb begin
    state_next = state;
    IE         = 1'b0;
    WE         = 1'b0;
    OE         = 1'b0;
    ADDR_WR    = 3'd0;
    ADDR_RDA   = 3'd0;
    ADDR_RDB   = 3'd0;
    ALU_Op     = 2'b00;
    dp_data_o  = '0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          // Operands with the top bit set are rejected without touching the datapath
          state_next = operand_i[DATA_WIDTH-1] ? S_DONE : S_LD_N;
        end
      end
      S_LD_N: begin
        IE         = 1'b1;
        WE         = 1'b1;
        ADDR_WR    = R_REM;
        dp_data_o  = operand_q;
        state_next = S_LD_ODD;
      end
      S_LD_ODD: begin
        IE         = 1'b1;
        WE         = 1'b1;
        ADDR_WR    = R_ODD;
        dp_data_o  = DATA_WIDTH'(1);
        state_next = S_LD_ONE;
      end
      S_LD_ONE: begin
        IE         = 1'b1;
        WE         = 1'b1;
        ADDR_WR    = R_ONE;
        dp_data_o  = DATA_WIDTH'(1);
        state_next = S_LD_TWO;
      end
      S_LD_TWO: begin
        IE         = 1'b1;
        WE         = 1'b1;
        ADDR_WR    = R_TWO;
        dp_data_o  = DATA_WIDTH'(2);
        state_next = S_LD_CNT;
      end
      S_LD_CNT: begin
        IE         = 1'b1;
        WE         = 1'b1;
        ADDR_WR    = R_CNT;
        dp_data_o  = '0;
        state_next = S_SUB;
      end
      S_SUB: begin
        ALU_Op     = OP_SUB;
        ADDR_RDA   = R_REM;
        ADDR_RDB   = R_ODD;
        ADDR_WR    = R_REM;
        WE         = ~negative_o_i;
        state_next = negative_o_i ? S_OUT : S_ADD_ODD;
      end
      S_ADD_ODD: begin
        ALU_Op     = OP_ADD;
        ADDR_RDA   = R_ODD;
        ADDR_RDB   = R_TWO;
        ADDR_WR    = R_ODD;
        WE         = 1'b1;
        state_next = S_INC;
      end
      S_INC: begin
        ALU_Op     = OP_ADD;
        ADDR_RDA   = R_CNT;
        ADDR_RDB   = R_ONE;
        ADDR_WR    = R_CNT;
        WE         = 1'b1;
        state_next = S_SUB;
      end
      S_OUT: begin
        ALU_Op     = OP_PASS;
        ADDR_RDA   = R_CNT;
        OE         = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done_o     = 1'b1;
        err_o      = err_q;
        state_next = S_IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sqrt_controller.sv
// Bench for sqrt_controller: a behavioural FP_Datapath closes the loop, and a
// plain-arithmetic integer square root plus the 3k+8 latency rule supply the
// expected results.
`timescale 1ns/1ps
module tb_sqrt_controller;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_i = 1'b0;
  logic [W-1:0] operand_i = '0;
  logic         negative_o_i;
  logic         IE, WE, OE;
  logic [2:0]   ADDR_WR, ADDR_RDA, ADDR_RDB;
  logic [1:0]   ALU_Op;
  logic [W-1:0] dp_data_o;
  logic         busy_o, done_o, err_o;

  sqrt_controller #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .operand_i    (operand_i),
    .negative_o_i (negative_o_i),
    .IE           (IE),
    .WE           (WE),
    .OE           (OE),
    .ADDR_WR      (ADDR_WR),
    .ADDR_RDA     (ADDR_RDA),
    .ADDR_RDB     (ADDR_RDB),
    .ALU_Op       (ALU_Op),
    .dp_data_o    (dp_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // ---------------- datapath model ----------------
  logic [W-1:0] rf [8];
  logic [W-1:0] alu_res;
  logic [W-1:0] dp_q;

  always_comb begin
    case (ALU_Op)
      2'b00:   alu_res = rf[ADDR_RDA] + rf[ADDR_RDB];
      2'b01:   alu_res = rf[ADDR_RDA] - rf[ADDR_RDB];
      default: alu_res = rf[ADDR_RDA];
    endcase
  end
  assign negative_o_i = alu_res[W-1];

  always @(posedge clk) begin
    if (WE) rf[ADDR_WR] <= IE ? dp_data_o : alu_res;
    if (OE) dp_q <= alu_res;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] n);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(n)) r++;
    return W'(r);
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, ALU_Op, dp_data_o, busy_o, done_o, err_o});
  endfunction

  // ---------------- driver ----------------
  // One complete request: drive start for a single edge, then watch every cycle.
  task automatic run_op(input logic [W-1:0] n);
    logic [W-1:0] exp_res, got_exp;
    int  exp_lat;
    bit  exp_err;
    bit  seen = 0;
    bit  busy_ok = 1;
    int  wr_cnt = 0;
    exp_err = n[W-1];
    if (exp_err) begin
      exp_res = dp_q;
      exp_lat = 1;
    end else begin
      exp_res = isqrt(n);
      exp_lat = 3 * int'(exp_res) + 8;
    end
    exp_q.push_back(exp_res);
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = n;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int cyc = 1; cyc <= exp_lat + 20 && !seen; cyc++) begin
      @(negedge clk);
      if (!busy_o) busy_ok = 0;
      if (WE || OE) wr_cnt++;
      if (done_o) begin
        seen = 1;
        got_exp = exp_q.pop_front();
        check($sformatf("latency N=%0d", n), cyc, exp_lat);
        check($sformatf("err N=%0d", n), err_o, exp_err);
        check($sformatf("result N=%0d", n), dp_q, got_exp);
      end
    end
    check($sformatf("done_seen N=%0d", n), seen, 1);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    check($sformatf("busy_window N=%0d", n), busy_ok, 1);
    if (exp_err) check("err_no_writes", wr_cnt, 0);
    @(negedge clk);
    check($sformatf("done_one_cycle N=%0d", n), done_o, 0);
    check($sformatf("idle_after N=%0d", n), busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    int done_cyc [2];
    logic [W-1:0] res_first;
    bit no_done;

    // reset state
    #12;
    check("reset_outputs", all_outputs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 64'd0);

    // directed values, including either side of a perfect square
    run_op(32'd0);
    run_op(32'd16);
    run_op(32'd15);
    run_op(32'd1);
    run_op(32'd3);
    run_op(32'h8000_0000);
    run_op(32'hFFFF_FFFF);
    run_op(32'd1048575);

    // start held high: one request per pass through IDLE
    done_cnt = 0;
    done_cyc[0] = 0;
    done_cyc[1] = 0;
    res_first = '0;
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = 32'd9;
    @(posedge clk);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        if (done_cnt < 2) done_cyc[done_cnt] = cyc;
        if (done_cnt == 0) res_first = dp_q;
        done_cnt++;
      end
      if (cyc == 36) start_i = 1'b0;
    end
    check("held_done_count", done_cnt, 2);
    check("held_first_cycle", done_cyc[0], 17);
    check("held_second_cycle", done_cyc[1], 35);
    check("held_result", res_first, 32'd3);
    @(negedge clk);
    check("held_idle_after", busy_o, 0);

    // asynchronous reset in the middle of the loop
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = 32'd100;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) @(negedge clk);
    check("busy_before_abort", busy_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs", all_outputs(), 64'd0);
    no_done = 1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done_o) no_done = 0;
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done_o) no_done = 0;
    end
    check("abort_no_done", no_done, 1);
    run_op(32'd100);

    // random operands below 2^20
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom_range(0, (1 << 20) - 1)));
    end
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 200)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global guard so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
